bidicntr_seq_checker: RTL and testbench

//  Receive-side checker for the bidirectional up/down counter stream on the user GPIO pads.
//  - Samples the WIDTH-bit count bus and its direction control every clock.
//  - Locks onto the sequence, then verifies each sample is the previous sample +1 or -1, with wrap-around.
//  - Reports lock status, a sticky error flag, a saturating error count and the last offending value.
//  - Sits in the user project beside the counter; fed from io_in or looped back from io_out.

---
 rtl/bidicntr_seq_checker.sv | 162 ++++++++++++++++
 tb/tb_bidicntr_seq_checker.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/bidicntr_seq_checker.sv
// Receive-side checker for the bidirectional up/down counter stream: locks onto
// the sequence, then flags every sample that is not previous +1/-1 (with wrap).
module bidicntr_seq_checker #(
    parameter int WIDTH    = 8,
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3,
    parameter int ERR_W    = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             en,
    input  logic             dir,
    input  logic [WIDTH-1:0] count_in,
    input  logic             err_clr,
    output logic             locked,
    output logic             err_sticky,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt,
    output logic [WIDTH-1:0] last_bad,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ACQ  = 2'b01,
        ST_LOCK = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   prev_cnt_q, prev_cnt_d;
    logic               prev_dir_q, prev_dir_d;
    logic               prev_vld_q, prev_vld_d;
    logic [3:0]         match_run_q, match_run_d;
    logic [3:0]         miss_run_q, miss_run_d;
    logic               locked_q, locked_d;
    logic               err_sticky_q, err_sticky_d;
    logic               err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
    logic [WIDTH-1:0]   last_bad_q, last_bad_d;
    logic [WIDTH-1:0]   exp_cnt;
    logic               match;

    always_comb begin
        exp_cnt = prev_dir_q ? prev_cnt_q + WIDTH'(1) : prev_cnt_q - WIDTH'(1);
        match   = prev_vld_q && (count_in == exp_cnt);

        state_d      = state_q;
        prev_cnt_d   = prev_cnt_q;
        prev_dir_d   = prev_dir_q;
        prev_vld_d   = prev_vld_q;
        match_run_d  = match_run_q;
        miss_run_d   = miss_run_q;
        locked_d     = locked_q;
        err_sticky_d = err_sticky_q;
        err_pulse_d  = 1'b0;
        err_cnt_d    = err_cnt_q;
        last_bad_d   = last_bad_q;

        if (!en) begin
            state_d     = ST_IDLE;
            prev_vld_d  = 1'b0;
            locked_d    = 1'b0;
            match_run_d = '0;
            miss_run_d  = '0;
        end else begin
            // The observed value is always carried forward, so one bad sample
            // costs two mismatches: entering it and leaving it.
            prev_cnt_d = count_in;
            prev_dir_d = dir;
            prev_vld_d = 1'b1;
            case (state_q)
                ST_IDLE: begin
                    state_d     = ST_ACQ;
                    prev_vld_d  = 1'b0;
                    match_run_d = '0;
                end
                ST_ACQ: begin
                    if (prev_vld_q) begin
                        if (match) begin
                            if (match_run_q == 4'(LOCK_CNT - 1)) begin
                                state_d     = ST_LOCK;
                                locked_d    = 1'b1;
                                miss_run_d  = '0;
                                match_run_d = '0;
                            end else begin
                                match_run_d = match_run_q + 4'd1;
                            end
                        end else begin
                            match_run_d = '0;
                        end
                    end
                end
                ST_LOCK: begin
                    if (match) begin
                        miss_run_d = '0;
                    end else begin
                        err_pulse_d  = 1'b1;
                        err_sticky_d = 1'b1;
                        last_bad_d   = count_in;
                        if (err_cnt_q != '1)
                            err_cnt_d = err_cnt_q + ERR_W'(1);
                        if (miss_run_q == 4'(LOSS_CNT - 1)) begin
                            state_d     = ST_ACQ;
                            locked_d    = 1'b0;
                            match_run_d = '0;
                            miss_run_d  = '0;
                        end else begin
                            miss_run_d = miss_run_q + 4'd1;
                        end
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    locked_d = 1'b0;
                end
            endcase
        end

        // Clear beats a coincident error; the pulse for that error still fires.
        if (err_clr) begin
            err_cnt_d    = '0;
            err_sticky_d = 1'b0;
            last_bad_d   = '0;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q      <= ST_IDLE;
            prev_cnt_q   <= '0;
            prev_dir_q   <= 1'b0;
            prev_vld_q   <= 1'b0;
            match_run_q  <= '0;
            miss_run_q   <= '0;
            locked_q     <= 1'b0;
            err_sticky_q <= 1'b0;
            err_pulse_q  <= 1'b0;
            err_cnt_q    <= '0;
            last_bad_q   <= '0;
        end else begin
            state_q      <= state_d;
            prev_cnt_q   <= prev_cnt_d;
            prev_dir_q   <= prev_dir_d;
            prev_vld_q   <= prev_vld_d;
            match_run_q  <= match_run_d;
            miss_run_q   <= miss_run_d;
            locked_q     <= locked_d;
            err_sticky_q <= err_sticky_d;
            err_pulse_q  <= err_pulse_d;
            err_cnt_q    <= err_cnt_d;
            last_bad_q   <= last_bad_d;
        end
    end

    assign locked     = locked_q;
    assign err_sticky = err_sticky_q;
    assign err_pulse  = err_pulse_q;
    assign err_cnt    = err_cnt_q;
    assign last_bad   = last_bad_q;
    assign state      = state_q;

endmodule

// File: tb/tb_bidicntr_seq_checker.sv
// Directed bench for bidicntr_seq_checker; a second instance with a 4-bit error
// counter shares the stimulus so saturation is reachable in a short run.
module tb_bidicntr_seq_checker;

    logic        clk;
    logic        rst;
    logic        en;
    logic        dir;
    logic [7:0]  count_in;
    logic        err_clr;

    logic        locked, err_sticky, err_pulse;
    logic [15:0] err_cnt;
    logic [7:0]  last_bad;
    logic [1:0]  state;

    logic        s_locked, s_err_sticky, s_err_pulse;
    logic [3:0]  s_err_cnt;
    logic [7:0]  s_last_bad;
    logic [1:0]  s_state;

    int n_cmp = 0;
    int n_bad = 0;
    int pulse_cnt = 0;
    logic [7:0] cur;

    bidicntr_seq_checker #(.WIDTH(8), .LOCK_CNT(4), .LOSS_CNT(3), .ERR_W(16)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .en(en), .dir(dir), .count_in(count_in),
        .err_clr(err_clr), .locked(locked), .err_sticky(err_sticky),
        .err_pulse(err_pulse), .err_cnt(err_cnt), .last_bad(last_bad), .state(state)
    );

    bidicntr_seq_checker #(.WIDTH(8), .LOCK_CNT(4), .LOSS_CNT(3), .ERR_W(4)) dut_sat (
        .wb_clk_i(clk), .wb_rst_i(rst), .en(en), .dir(dir), .count_in(count_in),
        .err_clr(err_clr), .locked(s_locked), .err_sticky(s_err_sticky),
        .err_pulse(s_err_pulse), .err_cnt(s_err_cnt), .last_bad(s_last_bad), .state(s_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one sample, clock it, and sample outputs 1 time unit later.
    task automatic step(input logic [7:0] c, input logic d);
        count_in = c;
        dir      = d;
        @(posedge clk);
        #1;
        if (err_pulse) pulse_cnt++;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; dir = 1'b0; count_in = 8'd0; err_clr = 1'b0;
        #2;
        chk_eq("rst_state",   32'(state), 0);
        chk_eq("rst_locked",  32'(locked), 0);
        chk_eq("rst_err_cnt", 32'(err_cnt), 0);
        chk_eq("rst_sticky",  32'(err_sticky), 0);
        chk_eq("rst_lastbad", 32'(last_bad), 0);
        chk_eq("rst_pulse",   32'(err_pulse), 0);
        @(negedge clk);
        rst = 1'b0;

        // Up ramp acquisition: one IDLE edge, one load, four matches.
        en = 1'b1;
        step(8'd10, 1'b1);
        chk_eq("t1_acq_state", 32'(state), 1);
        step(8'd10, 1'b1);
        step(8'd11, 1'b1);
        step(8'd12, 1'b1);
        step(8'd13, 1'b1);
        chk_eq("t1_not_yet_locked", 32'(state), 1);
        step(8'd14, 1'b1);
        chk_eq("t1_lock_state", 32'(state), 2);
        chk_eq("t1_locked",     32'(locked), 1);
        chk_eq("t1_err_cnt",    32'(err_cnt), 0);

        // Turn around and run down through the wrap.
        pulse_cnt = 0;
        step(8'd15, 1'b0);
        for (int v = 14; v >= 0; v--) step(8'(v), 1'b0);
        step(8'd255, 1'b0);
        chk_eq("t2_pulse_cnt", 32'(pulse_cnt), 0);
        chk_eq("t2_err_cnt",   32'(err_cnt), 0);

        // Turn up through the wrap, then toggle dir every sample.
        step(8'd254, 1'b1);
        step(8'd255, 1'b1);
        step(8'd0,   1'b1);
        step(8'd1,   1'b1);
        for (int v = 2; v <= 7; v++) step(8'(v), 1'b1);
        step(8'd8, 1'b0);
        step(8'd7, 1'b1);
        step(8'd8, 1'b0);
        step(8'd7, 1'b1);
        chk_eq("t3_pulse_cnt", 32'(pulse_cnt), 0);
        chk_eq("t3_err_cnt",   32'(err_cnt), 0);
        chk_eq("t3_locked",    32'(locked), 1);

        // Single corrupted sample: 40 in place of 21.
        for (int v = 8; v <= 20; v++) step(8'(v), 1'b1);
        step(8'd40, 1'b1);
        chk_eq("t4_pulse_first", 32'(err_pulse), 1);
        chk_eq("t4_lastbad_first", 32'(last_bad), 8'd40);
        step(8'd22, 1'b1);
        step(8'd23, 1'b1);
        chk_eq("t4_pulse_gone", 32'(err_pulse), 0);
        step(8'd24, 1'b1);
        chk_eq("t4_pulse_cnt", 32'(pulse_cnt), 2);
        chk_eq("t4_err_cnt",   32'(err_cnt), 2);
        chk_eq("t4_last_bad",  32'(last_bad), 22);
        chk_eq("t4_sticky",    32'(err_sticky), 1);
        chk_eq("t4_locked",    32'(locked), 1);

        // Clear, then three consecutive misses drop lock; four matches relock.
        err_clr = 1'b1;
        step(8'd25, 1'b1);
        err_clr = 1'b0;
        chk_eq("t5_clr_cnt",    32'(err_cnt), 0);
        chk_eq("t5_clr_sticky", 32'(err_sticky), 0);
        chk_eq("t5_clr_lastbad", 32'(last_bad), 0);
        step(8'd100, 1'b1);
        step(8'd100, 1'b1);
        chk_eq("t5_still_locked", 32'(locked), 1);
        step(8'd100, 1'b1);
        chk_eq("t5_loss_state",  32'(state), 1);
        chk_eq("t5_loss_locked", 32'(locked), 0);
        chk_eq("t5_loss_errcnt", 32'(err_cnt), 3);
        step(8'd101, 1'b1);
        step(8'd102, 1'b1);
        step(8'd103, 1'b1);
        chk_eq("t5_no_early_relock", 32'(state), 1);
        step(8'd104, 1'b1);
        chk_eq("t5_relock_state", 32'(state), 2);
        chk_eq("t5_relock_locked", 32'(locked), 1);
        chk_eq("t5_err_cnt", 32'(err_cnt), 3);

        // Alternate miss/match to stay locked while the 4-bit counter saturates.
        cur = 8'd104;
        for (int i = 0; i < 14; i++) begin
            step(cur + 8'd5, 1'b1);
            step(cur + 8'd6, 1'b1);
            cur = cur + 8'd6;
        end
        chk_eq("t6_err_cnt_main", 32'(err_cnt), 17);
        chk_eq("t6_err_cnt_sat",  32'(s_err_cnt), 15);
        chk_eq("t6_locked",       32'(locked), 1);

        // Clear coincident with a mismatch: clear wins, pulse still fires.
        err_clr = 1'b1;
        step(cur + 8'd5, 1'b1);
        err_clr = 1'b0;
        chk_eq("t6_clr_pulse",    32'(err_pulse), 1);
        chk_eq("t6_clr_cnt_main", 32'(err_cnt), 0);
        chk_eq("t6_clr_cnt_sat",  32'(s_err_cnt), 0);
        chk_eq("t6_clr_sticky",   32'(err_sticky), 0);
        chk_eq("t6_clr_lastbad",  32'(last_bad), 0);

        // One more miss, then disable: error state is retained in IDLE.
        step(8'd200, 1'b1);
        chk_eq("t7_err_cnt", 32'(err_cnt), 1);
        en = 1'b0;
        step(8'd201, 1'b1);
        chk_eq("t7_idle_state",   32'(state), 0);
        chk_eq("t7_idle_locked",  32'(locked), 0);
        chk_eq("t7_idle_pulse",   32'(err_pulse), 0);
        chk_eq("t7_idle_errcnt",  32'(err_cnt), 1);
        chk_eq("t7_idle_sticky",  32'(err_sticky), 1);
        chk_eq("t7_idle_lastbad", 32'(last_bad), 200);

        // Relock, take a miss, then assert reset between edges.
        en = 1'b1;
        step(8'd50, 1'b1);
        for (int v = 50; v <= 54; v++) step(8'(v), 1'b1);
        chk_eq("t8_relocked", 32'(locked), 1);
        step(8'd99, 1'b1);
        chk_eq("t8_pulse",   32'(err_pulse), 1);
        chk_eq("t8_lastbad", 32'(last_bad), 99);
        #2;
        rst = 1'b1;
        #1;
        chk_eq("t8_arst_state",   32'(state), 0);
        chk_eq("t8_arst_locked",  32'(locked), 0);
        chk_eq("t8_arst_pulse",   32'(err_pulse), 0);
        chk_eq("t8_arst_errcnt",  32'(err_cnt), 0);
        chk_eq("t8_arst_sticky",  32'(err_sticky), 0);
        chk_eq("t8_arst_lastbad", 32'(last_bad), 0);
        chk_eq("t8_arst_sat_state", 32'({s_locked, s_err_sticky, s_err_pulse, s_last_bad, s_state}), 0);
        @(negedge clk);
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
